// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared constants for the iterative divider. These sit beside
//               the pipeline constants: state codes, ready/start encodings,
//               the reset level and the double-width result bus size.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Reset level
  localparam logic RstEnable = 1'b1;

  // Divider state codes (2-bit)
  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  // Handshake encodings
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Width of the {Hi, Lo} result bus
  localparam int DoubleRegBus = 64;

  typedef enum logic [1:0] {
    ST_FREE    = DivFree,
    ST_BY_ZERO = DivByZero,
    ST_ON      = DivOn,
    ST_END     = DivEnd
  } div_state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One radix-2 restoring division iteration (combinational).
//               Compares the upper half of the working register with the
//               divisor; on success the difference replaces the upper half
//               and a 1 quotient bit is shifted in, otherwise a 0.
// Ports       : i_work    - working register {partial rem, dividend/quotient}
//               i_divisor - |divisor|
//               o_work    - working register after this iteration
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  i_work,
  input  logic [WIDTH-1:0]  i_divisor,
  output logic [2*WIDTH:0]  o_work
);

  logic [WIDTH:0] w_diff;

  // One extra bit so the borrow shows up as the sign of the difference.
  assign w_diff = {1'b0, i_work[2*WIDTH-1:WIDTH]} - {1'b0, i_divisor};

  always_comb begin
    o_work = '0;
    if (w_diff[WIDTH]) begin
      o_work = {i_work[2*WIDTH-1:0], 1'b0};
    end else begin
      o_work = {w_diff[WIDTH-1:0], i_work[WIDTH-1:0], 1'b1};
    end
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
// Module      : div
// Description : Iterative signed/unsigned integer divider (DIV/DIVU). One
//               quotient bit per clock; WIDTH+2 cycles from start to ready.
//               Result is {remainder, quotient}, ready to write into {Hi, Lo}.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               signed_div_i - 1 = signed, 0 = unsigned
//               opdata1_i    - dividend
//               opdata2_i    - divisor
//               start_i      - DivStart requests/holds, DivStop releases
//               annul_i      - abandon a division in progress
//               result_o     - {remainder, quotient}
//               ready_o      - high while result_o is valid
// Revision    : 1.0 - initial release
// ============================================================================
module div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH);

  div_state_e           r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [2*WIDTH:0]     r_work;
  logic [WIDTH-1:0]     r_divisor;
  logic                 r_neg_q;
  logic                 r_neg_r;

  logic [WIDTH-1:0]     w_op1_abs;
  logic [WIDTH-1:0]     w_op2_abs;
  logic [2*WIDTH:0]     w_step;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // Magnitudes of the operands. The most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  assign w_op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ?
                     (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign w_op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ?
                     (~opdata2_i + WIDTH'(1)) : opdata2_i;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_step)
  );

  // The initial left shift of the dividend leaves the remainder one bit up
  // from the top of the register once all quotient bits are in.
  assign w_quot     = r_work[WIDTH-1:0];
  assign w_rem      = r_work[2*WIDTH:WIDTH+1];
  assign w_quot_fix = r_neg_q ? (~w_quot + WIDTH'(1)) : w_quot;
  assign w_rem_fix  = r_neg_r ? (~w_rem  + WIDTH'(1)) : w_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_state   <= ST_FREE;
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DivResultNotReady;
    end else begin
      case (r_state)
        ST_FREE: begin
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (start_i == DivStart && !annul_i) begin
            if (opdata2_i == '0) begin
              r_state <= ST_BY_ZERO;
            end else begin
              r_state   <= ST_ON;
              r_cnt     <= '0;
              r_divisor <= w_op2_abs;
              r_neg_q   <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              r_neg_r   <= signed_div_i & opdata1_i[WIDTH-1];
              r_work    <= {WIDTH'(0), w_op1_abs, 1'b0};
            end
          end
        end

        ST_BY_ZERO: begin
          result_o <= '0;
          if (annul_i) begin
            r_state <= ST_FREE;
            ready_o <= DivResultNotReady;
          end else begin
            r_state <= ST_END;
            ready_o <= DivResultReady;
          end
        end

        ST_ON: begin
          if (annul_i) begin
            r_state  <= ST_FREE;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end else if (r_cnt != c_last) begin
            r_work <= w_step;
            r_cnt  <= r_cnt + c_cnt_w'(1);
          end else begin
            result_o <= {w_rem_fix, w_quot_fix};
            ready_o  <= DivResultReady;
            r_state  <= ST_END;
          end
        end

        ST_END: begin
          // Flushes are ignored here; only DivStop releases the result.
          if (start_i == DivStop) begin
            r_state  <= ST_FREE;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end

        default: begin
          r_state  <= ST_FREE;
          result_o <= '0;
          ready_o  <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule : div
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_div
// Description : Directed self-checking bench for the iterative divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int passes = 0;
  int n;

  always #5 clk = ~clk;

  div #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Launch a division and count edges (start edge included) until ready.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int edges);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    edges        = 0;
    do begin
      tick();
      edges++;
    end while (ready_o !== 1'b1 && edges < 100);
  endtask

  task automatic release_div(input string tag);
    start_i = 1'b0;
    tick();
    check({tag, "_rel_ready"}, {63'd0, ready_o}, 64'd0);
    check({tag, "_rel_result"}, result_o, 64'd0);
  endtask

  initial begin
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    check("reset_ready", {63'd0, ready_o}, 64'd0);
    check("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick();

    // Unsigned 100 / 7
    run_div(1'b0, 32'd100, 32'd7, n);
    check("u100_7_latency", 64'(n), 64'd34);
    check("u100_7_result", result_o, 64'h00000002_0000000E);
    release_div("u100_7");

    // Signed -7 / 2, then the same bits unsigned
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, n);
    check("s_m7_2_result", result_o, 64'hFFFFFFFF_FFFFFFFD);
    release_div("s_m7_2");
    run_div(1'b0, 32'hFFFFFFF9, 32'd2, n);
    check("u_m7_2_result", result_o, 64'h00000001_7FFFFFFC);
    release_div("u_m7_2");

    // Signed 7 / -2 and -7 / -2: remainder sign follows the dividend
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, n);
    check("s_7_m2_result", result_o, 64'h00000001_FFFFFFFD);
    release_div("s_7_m2");
    run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, n);
    check("s_m7_m2_result", result_o, 64'hFFFFFFFF_00000003);
    release_div("s_m7_m2");

    // Divide by zero
    run_div(1'b0, 32'd100, 32'd0, n);
    check("div0_latency", 64'(n), 64'd2);
    check("div0_ready", {63'd0, ready_o}, 64'd1);
    check("div0_result", result_o, 64'd0);
    release_div("div0");

    // Annul at iteration 10, then restart immediately with 9 / 3
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFFFFFF;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    tick();
    repeat (10) tick();
    annul_i = 1'b1;
    tick();
    check("annul_ready_a", {63'd0, ready_o}, 64'd0);
    tick();
    check("annul_ready_b", {63'd0, ready_o}, 64'd0);
    run_div(1'b0, 32'd9, 32'd3, n);
    check("restart_latency", 64'(n), 64'd34);
    check("restart_result", result_o, 64'h00000000_00000003);
    release_div("restart");

    // Signed overflow, held for 5 extra cycles
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, n);
    check("ovf_result", result_o, 64'h00000000_80000000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ovf_hold_result", result_o, 64'h00000000_80000000);
      check("ovf_hold_ready", {63'd0, ready_o}, 64'd1);
    end
    release_div("ovf");

    // Asynchronous reset at iteration 20
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    tick();
    repeat (20) tick();
    #1 rst = 1'b1;
    #1;
    check("arst_mid_ready", {63'd0, ready_o}, 64'd0);
    check("arst_mid_result", result_o, 64'd0);
    start_i = 1'b0;
    rst     = 1'b0;
    tick();
    check("arst_free_ready", {63'd0, ready_o}, 64'd0);
    run_div(1'b0, 32'd50, 32'd5, n);
    check("after_rst_latency", 64'(n), 64'd34);
    check("after_rst_result", result_o, 64'h00000000_0000000A);

    // Asynchronous reset while a result is held clears it between edges
    #1 rst = 1'b1;
    #1;
    check("arst_end_ready", {63'd0, ready_o}, 64'd0);
    check("arst_end_result", result_o, 64'd0);
    start_i = 1'b0;
    rst     = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule : tb_div
`default_nettype wire

// File: doc/div.md
Name: div

Overview:
- Iterative multi-cycle integer divider for the MIPS32 core; serves DIV/DIVU.
- Sits beside the execute stage. EX supplies operands, sign mode and a start request, and stalls the pipeline until ready_o is seen.
- Returns {remainder, quotient} as a 64-bit word so EX can write it straight into {Hi, Lo}.
- Radix-2 restoring algorithm: one quotient bit per clock; WIDTH+2 cycles from start to ready.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  WIDTH  dividend
- opdata2_i  in  WIDTH  divisor
- start_i  in  1  DivStart = request/hold a division; DivStop = release
- annul_i  in  1  1 = abandon any division in progress (pipeline flush)
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}
- ready_o  out  1  DivResultReady while result_o is valid

Behaviour:
- Reset: asynchronous, active-high, clock and reset as stated above.
  - While rst is high: state = FREE, cnt = 0, working registers = 0, result_o = 0, ready_o = DivResultNotReady.
  - Takes effect immediately, including mid-division. No partial result ever escapes.
- All outputs are registered. Operands are latched only on the start edge, so EX may change inputs afterwards.
- FREE state:
  - start_i = DivStart, annul_i = 0, opdata2_i = 0: go to BY_ZERO.
  - start_i = DivStart, annul_i = 0, opdata2_i != 0: go to ON, cnt = 0.
    - Latch abs values when signed_div_i = 1 and the operand MSB = 1; otherwise latch raw values.
    - Latch neg_q = signed & (op1 MSB ^ op2 MSB).
    - Latch neg_r = signed & op1 MSB.
    - Working register (2*WIDTH+1 bits) = {0, |dividend|, 0}.
  - Any other input: stay in FREE; ready_o = 0, result_o = 0.
- ON state:
  - annul_i = 1: go to FREE, ready_o stays 0.
  - cnt < WIDTH: per clock, diff = upper half − |divisor| (WIDTH+1-bit subtract).
    - diff negative: shift the whole register left 1.
    - Otherwise: replace the upper half with diff[WIDTH-1:0], shift left, LSB = 1.
    - cnt increments.
  - cnt = WIDTH: quotient = low half; remainder = upper half (right-aligned).
    - Apply two's-complement negation per neg_q and neg_r.
    - Load result_o, set ready_o = 1, go to END.
- BY_ZERO state: next clock go to END with result_o = 0 and ready_o = 1. No exception is raised; the architectural result is UNPREDICTABLE.
- END state:
  - Hold result_o and ready_o while start_i = DivStart.
  - start_i = DivStop: go to FREE; ready_o = 0 and result_o = 0 on that edge.
- Latency, counting the start-sampling edge as E0:
  - ON iterations on E1..E32; ready_o rises after E33, i.e. 34 cycles for WIDTH = 32.
  - Divide by zero: ready_o rises after E1.
- Signed overflow, −2^31 / −1: quotient wraps to 0x80000000, remainder = 0. No trap.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).
- annul_i in BY_ZERO: go to FREE. In END: ignored; leave END only via DivStop.
- start_i dropped while in ON without annul: the division continues to END. Nothing restarts until DivStop is seen in END.

Decomposition:
- Shared defines header, alongside the existing pipeline constants:
  - DivFree / DivByZero / DivOn / DivEnd (2-bit state codes)
  - DivResultReady / DivResultNotReady
  - DivStart / DivStop
  - RstEnable (1'b1)
  - DoubleRegBus
- One natural combinational sub-module, div_step: takes the working register and divisor, returns the next working register. It keeps the shift-subtract datapath separate from the FSM.

Test Plan:
- Unsigned 100 / 7, held start → ready_o rises after 34 cycles; result_o = 0x00000002_0000000E.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002) → result_o = 0xFFFFFFFF_FFFFFFFD. Same operands unsigned → 0x00000001_7FFFFFFC.
- Divisor 0 → ready_o after 2 cycles; result_o = 0. Drop start → FREE next cycle with outputs 0.
- Start 0xFFFFFFFF / 3 unsigned, assert annul_i at iteration 10 → ready_o never rises. Immediate restart 9 / 3 → 0x00000000_00000003.
- Signed 0x80000000 / 0xFFFFFFFF → result_o = 0x00000000_80000000. Result stays stable for 5 extra cycles while start is held.
- Assert rst asynchronously at iteration 20 → outputs clear without a clock edge. After release, a new 50 / 5 → 0x00000000_0000000A.
